// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared opcode constants, stage states and decode helper
// Contents:
//   OP_*          4-bit opcodes in ir[3:0]
//   NOP_IR        full 8-bit bubble instruction
//   ST_*          mem_stage FSM encodings
//   is_mem_op()   1 when a valid instruction needs the data-memory port
package mem_stage_pkg;

   localparam logic [3:0] OP_LOAD  = 4'd0;
   localparam logic [3:0] OP_STOP  = 4'd1;
   localparam logic [3:0] OP_STORE = 4'd2;
   localparam logic [3:0] OP_NOP   = 4'd10;
   localparam logic [7:0] NOP_IR   = {4'h0, OP_NOP};

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic logic is_mem_op(input logic [7:0] ir, input logic valid);
      return valid && ((ir[3:0] == OP_LOAD) || (ir[3:0] == OP_STORE));
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - wait-cycle counter for outstanding memory accesses
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-high
//   clear     in   restart the count (access being issued)
//   count_en  in   one more cycle spent waiting
//   expired   out  the current waiting cycle is the TIMEOUT-th one
module mem_timeout_ctr #(
   parameter int TIMEOUT = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
   localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // cnt_q counts waiting cycles already completed, so it reads TIMEOUT-1
   // during the TIMEOUT-th cycle; saturate rather than wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (count_en && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign expired = (cnt_q == LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: LOAD/STORE over req/ack with bubbles and timeout
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   ir3, ir3_valid          instruction from EX and its valid flag
//   r3, addr3, wdata3       ALU result, effective address, store data from EX
//   ir4_load                writeback load enable (0 freezes ir4/r4/mdr4)
//   stall                   combinational hold request to upstream
//   mem_req, mem_we         data-memory request and direction (1 = store)
//   mem_addr, mem_wdata     request address and store data, stable while mem_req
//   mem_rdata, mem_ack      load data and single-cycle completion pulse
//   ir4, r4, mdr4           instruction, ALU result, load data to writeback
//   mem_err                 sticky memory-timeout flag
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        ir3,
   input  logic              ir3_valid,
   input  logic [DATA_W-1:0] r3,
   input  logic [ADDR_W-1:0] addr3,
   input  logic [DATA_W-1:0] wdata3,
   input  logic              ir4_load,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [7:0]        ir4,
   output logic [DATA_W-1:0] r4,
   output logic [DATA_W-1:0] mdr4,
   output logic              mem_err
);

   logic [1:0]        state_q, state_d;
   logic [7:0]        ir4_q, ir4_d;
   logic [DATA_W-1:0] r4_q, r4_d;
   logic [DATA_W-1:0] mdr4_q, mdr4_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_err_q, mem_err_d;
   // instruction/result parked while the access is outstanding or frozen
   logic [7:0]        lat_ir_q, lat_ir_d;
   logic [DATA_W-1:0] lat_r_q, lat_r_d;
   logic [DATA_W-1:0] lat_mdr_q, lat_mdr_d;

   logic ctr_clear;
   logic ctr_en;
   logic expired;
   logic lat_is_load;

   assign lat_is_load = (lat_ir_q[3:0] == OP_LOAD);

   mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clock    (clock),
      .reset    (reset),
      .clear    (ctr_clear),
      .count_en (ctr_en),
      .expired  (expired)
   );

   always_comb begin
      state_d     = state_q;
      ir4_d       = ir4_q;
      r4_d        = r4_q;
      mdr4_d      = mdr4_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_err_d   = mem_err_q;
      lat_ir_d    = lat_ir_q;
      lat_r_d     = lat_r_q;
      lat_mdr_d   = lat_mdr_q;
      stall       = 1'b0;
      ctr_clear   = 1'b0;
      ctr_en      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!ir4_load) begin
               stall = 1'b1;
            end else if (is_mem_op(ir3, ir3_valid)) begin
               stall       = 1'b1;
               state_d     = ST_WAIT;
               mem_req_d   = 1'b1;
               mem_we_d    = (ir3[3:0] == OP_STORE);
               mem_addr_d  = addr3;
               mem_wdata_d = wdata3;
               lat_ir_d    = ir3;
               lat_r_d     = r3;
               ir4_d       = NOP_IR;
               ctr_clear   = 1'b1;
            end else begin
               ir4_d = ir3_valid ? ir3 : NOP_IR;
               r4_d  = r3;
            end
         end

         // Upstream is released in the completing cycle (ack or timeout)
         // whatever ir4_load says: the instruction is already parked here,
         // so holding it would make it issue a second time.
         ST_WAIT: begin
            ctr_en = 1'b1;
            if (mem_ack) begin
               mem_req_d = 1'b0;
               if (ir4_load) begin
                  ir4_d   = lat_ir_q;
                  r4_d    = lat_r_q;
                  state_d = ST_IDLE;
                  if (lat_is_load) begin
                     mdr4_d = mem_rdata;
                  end
               end else begin
                  lat_mdr_d = mem_rdata;
                  state_d   = ST_DONE;
               end
            end else if (expired) begin
               mem_err_d = 1'b1;
               mem_req_d = 1'b0;
               state_d   = ST_IDLE;
               if (ir4_load) begin
                  ir4_d = NOP_IR;
               end
            end else begin
               stall = 1'b1;
               if (ir4_load) begin
                  ir4_d = NOP_IR;
               end
            end
         end

         ST_DONE: begin
            stall = 1'b1;
            if (ir4_load) begin
               ir4_d   = lat_ir_q;
               r4_d    = lat_r_q;
               state_d = ST_IDLE;
               if (lat_is_load) begin
                  mdr4_d = lat_mdr_q;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ir4_q       <= NOP_IR;
         r4_q        <= '0;
         mdr4_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_err_q   <= 1'b0;
         lat_ir_q    <= NOP_IR;
         lat_r_q     <= '0;
         lat_mdr_q   <= '0;
      end else begin
         state_q     <= state_d;
         ir4_q       <= ir4_d;
         r4_q        <= r4_d;
         mdr4_q      <= mdr4_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_err_q   <= mem_err_d;
         lat_ir_q    <= lat_ir_d;
         lat_r_q     <= lat_r_d;
         lat_mdr_q   <= lat_mdr_d;
      end
   end

   assign ir4       = ir4_q;
   assign r4        = r4_q;
   assign mdr4      = mdr4_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a cycle-level reference model
module tb_mem_stage;

   localparam int TO = 15;
   localparam logic [7:0] NOP = 8'h0A;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] ir3;
   logic       ir3_valid;
   logic [7:0] r3, addr3, wdata3;
   logic       ir4_load;
   logic       stall;
   logic       mem_req, mem_we;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_ack;
   logic [7:0] ir4, r4, mdr4;
   logic       mem_err;

   mem_stage #(.DATA_W(8), .ADDR_W(8), .TIMEOUT(TO)) dut (
      .clock     (clock),
      .reset     (reset),
      .ir3       (ir3),
      .ir3_valid (ir3_valid),
      .r3        (r3),
      .addr3     (addr3),
      .wdata3    (wdata3),
      .ir4_load  (ir4_load),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .ir4       (ir4),
      .r4        (r4),
      .mdr4      (mdr4),
      .mem_err   (mem_err)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference model: what writeback and the memory port should observe.
   logic [7:0] e_ir4, e_r4, e_mdr4, e_addr, e_wdata;
   bit         e_req, e_we, e_err, e_stall;
   bit         access_open;    // request on the bus, awaiting ack
   bit         result_parked;  // access finished, writeback frozen
   int         req_cycles;     // cycles mem_req has been high so far
   logic [7:0] p_ir, p_r, p_mdr;

   function automatic bit wants_mem();
      return ir3_valid && (ir3[3:0] == 4'd0 || ir3[3:0] == 4'd2);
   endfunction

   task automatic model_comb();
      if (access_open)
         e_stall = !(mem_ack || (req_cycles + 1 == TO));
      else if (result_parked || !ir4_load)
         e_stall = 1'b1;
      else
         e_stall = wants_mem();
   endtask

   task automatic model_edge();
      if (reset) begin
         e_ir4 = NOP; e_r4 = 0; e_mdr4 = 0; e_addr = 0; e_wdata = 0;
         e_req = 0; e_we = 0; e_err = 0;
         access_open = 0; result_parked = 0; req_cycles = 0;
      end else if (access_open) begin
         req_cycles++;
         if (mem_ack) begin
            access_open = 0;
            e_req = 0;
            if (ir4_load) begin
               e_ir4 = p_ir;
               e_r4  = p_r;
               if (p_ir[3:0] == 4'd0) e_mdr4 = mem_rdata;
            end else begin
               p_mdr = mem_rdata;
               result_parked = 1;
            end
         end else if (req_cycles == TO) begin
            access_open = 0;
            e_req = 0;
            e_err = 1;
            if (ir4_load) e_ir4 = NOP;
         end else if (ir4_load) begin
            e_ir4 = NOP;
         end
      end else if (result_parked) begin
         if (ir4_load) begin
            e_ir4 = p_ir;
            e_r4  = p_r;
            if (p_ir[3:0] == 4'd0) e_mdr4 = p_mdr;
            result_parked = 0;
         end
      end else if (ir4_load) begin
         if (wants_mem()) begin
            access_open = 1;
            req_cycles = 0;
            e_req = 1;
            e_we = (ir3[3:0] == 4'd2);
            e_addr = addr3;
            e_wdata = wdata3;
            p_ir = ir3;
            p_r = r3;
            e_ir4 = NOP;
         end else begin
            e_ir4 = ir3_valid ? ir3 : NOP;
            e_r4 = r3;
         end
      end
   endtask

   // One clock: inputs already driven after the falling edge.
   task automatic cycle();
      #1;
      model_comb();
      if (!reset) check_eq("stall", stall, e_stall);
      @(posedge clock);
      model_edge();
      #1;
      check_eq("ir4", ir4, e_ir4);
      check_eq("r4", r4, e_r4);
      check_eq("mdr4", mdr4, e_mdr4);
      check_eq("mem_req", mem_req, e_req);
      check_eq("mem_err", mem_err, e_err);
      if (e_req) begin
         check_eq("mem_we", mem_we, e_we);
         check_eq("mem_addr", mem_addr, e_addr);
         check_eq("mem_wdata", mem_wdata, e_wdata);
      end
      @(negedge clock);
   endtask

   task automatic put(input logic [7:0] ir, input bit v, input logic [7:0] r,
                      input logic [7:0] a, input logic [7:0] w);
      ir3 = ir; ir3_valid = v; r3 = r; addr3 = a; wdata3 = w;
   endtask

   int reqs;
   bit hold;

   initial begin
      reset = 1; ir4_load = 1; mem_ack = 0; mem_rdata = 0;
      put(8'h00, 0, 8'h00, 8'h00, 8'h00);
      @(negedge clock);
      cycle();
      check_eq("rst_ir4", ir4, 8'h0A);
      check_eq("rst_r4", r4, 0);
      check_eq("rst_mdr4", mdr4, 0);
      check_eq("rst_req", mem_req, 0);
      check_eq("rst_we", mem_we, 0);
      check_eq("rst_addr", mem_addr, 0);
      check_eq("rst_wdata", mem_wdata, 0);
      check_eq("rst_err", mem_err, 0);
      reset = 0;

      // ADD passes in one cycle
      put(8'h14, 1, 8'h3C, 8'h00, 8'h00);
      cycle();
      check_eq("add_ir4", ir4, 8'h14);
      check_eq("add_r4", r4, 8'h3C);

      // LOAD, ack in third request cycle
      put(8'h30, 1, 8'h11, 8'h20, 8'h00);
      cycle();
      check_eq("ld_addr", mem_addr, 8'h20);
      check_eq("ld_bubble", ir4, NOP);
      reqs = 0;
      for (int i = 0; i < 3; i++) begin
         mem_ack = (i == 2);
         mem_rdata = (i == 2) ? 8'hA5 : 8'h5A;
         if (mem_req) reqs++;
         cycle();
      end
      mem_ack = 0;
      check_eq("ld_req_cycles", reqs, 3);
      check_eq("ld_ir4", ir4, 8'h30);
      check_eq("ld_mdr4", mdr4, 8'hA5);

      // STORE acked after one cycle, ADD follows
      put(8'h52, 1, 8'h22, 8'h40, 8'h7E);
      cycle();
      check_eq("st_we", mem_we, 1);
      check_eq("st_wdata", mem_wdata, 8'h7E);
      mem_ack = 1; mem_rdata = 8'hEE;
      cycle();
      mem_ack = 0;
      put(8'h14, 1, 8'h3C, 8'h00, 8'h00);
      cycle();
      check_eq("st_next_ir4", ir4, 8'h14);
      check_eq("st_mdr4_kept", mdr4, 8'hA5);

      // LOAD never acked: timeout
      put(8'h30, 1, 8'h44, 8'h66, 8'h00);
      cycle();
      for (int i = 0; i < TO; i++) cycle();
      check_eq("to_req", mem_req, 0);
      check_eq("to_err", mem_err, 1);
      check_eq("to_ir4", ir4, NOP);
      put(8'h14, 1, 8'h3C, 8'h00, 8'h00);
      cycle();
      check_eq("to_err_sticky", mem_err, 1);

      // LOAD acked while writeback frozen
      put(8'h70, 1, 8'h33, 8'h21, 8'h00);
      cycle();
      ir4_load = 0; mem_ack = 1; mem_rdata = 8'hC3;
      cycle();
      mem_ack = 0;
      put(8'h14, 1, 8'h3C, 8'h00, 8'h00);
      #1;
      check_eq("frz_stall", stall, 1);
      cycle();
      check_eq("frz_ir4", ir4, NOP);
      check_eq("frz_mdr4", mdr4, 8'hA5);
      ir4_load = 1;
      cycle();
      check_eq("frz_rel_ir4", ir4, 8'h70);
      check_eq("frz_rel_mdr4", mdr4, 8'hC3);
      cycle();
      check_eq("frz_next_ir4", ir4, 8'h14);

      // reset in the middle of an access, late ack ignored
      put(8'h30, 1, 8'h55, 8'h77, 8'h00);
      cycle();
      cycle();
      reset = 1;
      cycle();
      reset = 0;
      put(8'h00, 0, 8'h00, 8'h00, 8'h00);
      mem_ack = 1; mem_rdata = 8'h99;
      cycle();
      mem_ack = 0;
      check_eq("rw_req", mem_req, 0);
      check_eq("rw_ir4", ir4, NOP);
      check_eq("rw_mdr4", mdr4, 0);
      check_eq("rw_err", mem_err, 0);

      // randomized traffic; upstream holds its instruction while stalled
      hold = 0;
      for (int n = 0; n < 800; n++) begin
         if (!hold) begin
            int sel;
            logic [3:0] op;
            sel = $urandom_range(0, 9);
            op = (sel < 3) ? 4'd0 : (sel < 6) ? 4'd2 : (sel == 6) ? 4'd1 :
                 (sel == 7) ? 4'd10 : 4'($urandom_range(0, 15));
            put({4'($urandom_range(0, 15)), op}, $urandom_range(0, 7) != 0,
                8'($urandom), 8'($urandom), 8'($urandom));
         end
         ir4_load = $urandom_range(0, 9) != 0;
         mem_ack = $urandom_range(0, 3) == 0;
         mem_rdata = 8'($urandom);
         reset = $urandom_range(0, 199) == 0;
         cycle();
         hold = e_stall && !reset;
      end
      reset = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
